// File: rtl/gpio_event_reporter.sv
// Debounced rising-edge event flag for a QNX GPIO input pin, held until ack or hold timeout.
// Optional dropped-event counter enabled by defining GPIO_EVT_MISSCNT_EN.
module gpio_event_reporter #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_MAX        = 25000000,
  parameter int CNT_W           = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sense_in,
  input  logic       ack,
  output logic       event_out,
  output logic       busy
`ifdef GPIO_EVT_MISSCNT_EN
  ,
  output logic [7:0] missed_count
`endif
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With HOLD_MAX == 0 this wraps to all-ones, which doubles as the saturation point.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam bit               HOLD_EN   = (HOLD_MAX != 0);

  typedef enum logic [1:0] {
    IDLE,
    REPORT,
    CLEAR
  } state_t;

  logic             sync_meta;
  logic             s_sync;
  logic             s_stable;
  logic             rise;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] hold_cnt;
  state_t           state;
  state_t           next_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b0;
      s_sync    <= 1'b0;
    end else begin
      sync_meta <= sense_in;
      s_sync    <= sync_meta;
    end
  end

  // rise is a one-cycle pulse registered alongside the accepted 0->1 level change.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_stable <= 1'b0;
      db_cnt   <= '0;
      rise     <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (s_sync == s_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        s_stable <= s_sync;
        db_cnt   <= '0;
        rise     <= s_sync;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (rise) next_state = REPORT;
      end
      REPORT: begin
        if (ack) begin
          next_state = CLEAR;
        end else if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
          next_state = CLEAR;
        end
      end
      CLEAR: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs are registered from next_state so they change cleanly with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      event_out <= 1'b0;
      busy      <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= next_state;
      event_out <= (next_state == REPORT);
      busy      <= (next_state != IDLE);
      if (state != REPORT) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

`ifdef GPIO_EVT_MISSCNT_EN
  logic dropped;

  assign dropped = rise && (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      missed_count <= 8'd0;
    end else if (dropped && (missed_count != 8'hFF)) begin
      missed_count <= missed_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpio_event_reporter.sv
// Scoreboard bench for gpio_event_reporter: each expected event_out pulse (start cycle, width)
// is queued when stimulus is driven and checked when the pulse ends.
module tb_gpio_event_reporter;

  localparam int DB  = 4;
  localparam int HM  = 20;
  localparam int LAT = DB + 3;

  typedef struct {
    int start;
    int len;
  } pulse_t;

  logic clock = 1'b0;
  logic reset;
  logic sense_in;
  logic ack;
  logic event_out;
  logic busy;
`ifdef GPIO_EVT_MISSCNT_EN
  logic [7:0] missed_count;
`endif

  int     cyc = 0;
  int     tests_run = 0;
  int     tests_failed = 0;
  pulse_t exp_q[$];

  gpio_event_reporter #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_MAX       (HM),
    .CNT_W          (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sense_in    (sense_in),
    .ack         (ack),
    .event_out   (event_out),
    .busy        (busy)
`ifdef GPIO_EVT_MISSCNT_EN
    ,
    .missed_count(missed_count)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, actual, expected);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic push_pulse(input int start, input int len);
    pulse_t p;
    p.start = start;
    p.len   = len;
    exp_q.push_back(p);
  endtask

  task automatic check_missed(input string tag, input int expected);
`ifdef GPIO_EVT_MISSCNT_EN
    check_output(tag, 32'(missed_count), expected);
`endif
  endtask

  // Pulse monitor: measures every event_out pulse and pops the matching expectation.
  logic prev_ev = 1'b0;
  int   ev_start = 0;

  always @(negedge clock) begin
    pulse_t p;
    if (event_out === 1'b1 && prev_ev == 1'b0) begin
      ev_start = cyc;
    end else if (event_out !== 1'b1 && prev_ev == 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_pulse", 32'(ev_start), 32'hFFFF_FFFF);
      end else begin
        p = exp_q.pop_front();
        check_output("pulse_start", 32'(ev_start), 32'(p.start));
        check_output("pulse_len", 32'(cyc - ev_start), 32'(p.len));
      end
    end
    prev_ev = (event_out === 1'b1);
  end

  initial begin
    int k;
    reset    = 1'b1;
    sense_in = 1'b0;
    ack      = 1'b0;
    repeat (3) @(negedge clock);
    check_output("reset_event_out", 32'(event_out), 0);
    check_output("reset_busy", 32'(busy), 0);
    check_missed("reset_missed", 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Clean edge, acknowledged by a one-cycle pulse
    k = cyc;
    sense_in = 1'b1;
    push_pulse(k + LAT, (k + 11) - (k + LAT));
    wait_to(k + LAT);
    check_output("edge_event_out", 32'(event_out), 1);
    check_output("edge_busy", 32'(busy), 1);
    wait_to(k + 10);
    ack = 1'b1;
    wait_to(k + 11);
    ack = 1'b0;
    check_output("ack_event_low", 32'(event_out), 0);
    check_output("ack_clear_busy", 32'(busy), 1);
    wait_to(k + 12);
    check_output("ack_idle_busy", 32'(busy), 0);
    sense_in = 1'b0;
    wait_to(k + 22);

    // Glitch shorter than the debounce window
    k = cyc;
    sense_in = 1'b1;
    wait_to(k + 3);
    sense_in = 1'b0;
    wait_to(k + 15);
    check_output("glitch_event_out", 32'(event_out), 0);
    check_output("glitch_busy", 32'(busy), 0);
    check_missed("glitch_missed", 0);

    // Timed release without ack
    k = cyc;
    sense_in = 1'b1;
    push_pulse(k + LAT, HM);
    wait_to(k + LAT + HM);
    check_output("timeout_clear_low", 32'(event_out), 0);
    check_output("timeout_clear_busy", 32'(busy), 1);
    wait_to(k + LAT + HM + 1);
    check_output("timeout_idle_busy", 32'(busy), 0);
    sense_in = 1'b0;
    wait_to(k + LAT + HM + 12);

    // Overruns: a second debounced rise during every REPORT
    for (int i = 0; i < 300; i++) begin
      k = cyc;
      sense_in = 1'b1;
      push_pulse(k + LAT, HM);
      wait_to(k + 8);
      sense_in = 1'b0;
      wait_to(k + 16);
      sense_in = 1'b1;
      wait_to(k + 24);
      sense_in = 1'b0;
      wait_to(k + 32);
      if (i == 0) check_missed("overrun_missed_1", 1);
      if (i == 1) check_missed("overrun_missed_2", 2);
    end
    check_missed("overrun_saturate", 255);

    // Reset in the middle of REPORT with the input still high
    k = cyc;
    sense_in = 1'b1;
    push_pulse(k + LAT, 4);
    wait_to(k + 10);
    reset = 1'b1;
    wait_to(k + 11);
    reset = 1'b0;
    check_output("midrst_event_out", 32'(event_out), 0);
    check_output("midrst_busy", 32'(busy), 0);
    check_missed("midrst_missed", 0);
    push_pulse(k + 11 + LAT, HM);
    wait_to(k + 11 + LAT - 1);
    check_output("midrst_pre_event", 32'(event_out), 0);
    wait_to(k + 11 + LAT);
    check_output("midrst_new_event", 32'(event_out), 1);
    wait_to(k + 11 + LAT + HM + 2);
    sense_in = 1'b0;
    wait_to(cyc + 10);

    // ack held high across CLEAR into IDLE, then a fresh edge
    k = cyc;
    sense_in = 1'b1;
    push_pulse(k + LAT, 4);
    wait_to(k + 10);
    ack = 1'b1;
    wait_to(k + 12);
    sense_in = 1'b0;
    check_output("heldack_idle_busy", 32'(busy), 0);
    wait_to(k + 20);
    sense_in = 1'b1;
    push_pulse(k + 20 + LAT, 1);
    wait_to(k + 20 + LAT);
    check_output("heldack_event_high", 32'(event_out), 1);
    wait_to(k + 20 + LAT + 1);
    check_output("heldack_event_low", 32'(event_out), 0);
    wait_to(k + 20 + LAT + 2);
    check_output("heldack_idle", 32'(busy), 0);
    ack = 1'b0;
    sense_in = 1'b0;
    wait_to(cyc + 10);

    check_output("pulses_outstanding", 32'(exp_q.size()), 0);
    check_missed("final_missed", 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
